// File: rtl/logic_basic_gray2binary_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// logic_basic_gray2binary_stream
//
// Streaming gray-to-binary decoder with valid/ready handshakes on both sides.
// The MSB-to-LSB XOR chain is cut into STAGES register stages. Each stage
// resolves a contiguous chunk of at most ceil(WIDTH/STAGES) bits and passes the
// gray word and the partially resolved binary word on to the next stage.
//
// Each accepted word also carries a step-error flag (tx_tuser). It is set when
// the word differs from the previously accepted gray word in two or more bit
// positions. The first word after reset never flags.
//
// Parameters:
//   WIDTH  - gray/binary word width (>= 1)
//   STAGES - number of register stages, input acceptance to output (1..WIDTH)
//
// Ports:
//   aclk       - clock, rising edge
//   areset     - asynchronous active-high reset
//   rx_tvalid  - input word valid
//   rx_tready  - block can accept an input word
//   rx_tdata   - gray-coded input word
//   tx_tvalid  - output word valid
//   tx_tready  - downstream can accept an output word
//   tx_tdata   - binary-decoded output word
//   tx_tuser   - gray-step error flag for the word on tx_tdata
// -----------------------------------------------------------------------------
module logic_basic_gray2binary_stream #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    input  logic [WIDTH-1:0] rx_tdata,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [WIDTH-1:0] tx_tdata,
    output logic             tx_tuser
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    // Per-stage pipeline state
    logic [STAGES-1:0] vld_reg;
    logic [WIDTH-1:0]  gray_reg [STAGES];
    logic [WIDTH-1:0]  bin_reg  [STAGES];
    logic [STAGES-1:0] err_reg;

    // Step-error tracking
    logic [WIDTH-1:0]  prev_reg;
    logic              first_reg;

    // Stage inputs and the chunk-resolved result loaded into each stage
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vld_in;
    logic [WIDTH-1:0]  gray_in  [STAGES];
    logic [WIDTH-1:0]  bin_in   [STAGES];
    logic [WIDTH-1:0]  bin_next [STAGES];
    logic [STAGES-1:0] err_in;

    logic [WIDTH-1:0]  diff;
    logic              step_err;
    logic              rx_fire;

    // Resolve bits hi..lo of the binary word. Bits above hi are already final
    // in 'partial', so walking from the MSB the running carry is always the
    // resolved bit directly above the one being computed.
    function automatic logic [WIDTH-1:0] resolve_chunk(
        input logic [WIDTH-1:0] gray,
        input logic [WIDTH-1:0] partial,
        input int               hi,
        input int               lo
    );
        logic [WIDTH-1:0] res;
        logic             carry;
        res   = partial;
        carry = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (k <= hi && k >= lo) begin
                res[k] = carry ^ gray[k];
            end
            carry = res[k];
        end
        return res;
    endfunction

    // Two or more differing bits <=> clearing the lowest set bit leaves a
    // non-zero value.
    assign diff     = rx_tdata ^ prev_reg;
    assign step_err = ~first_reg & (|(diff & (diff - WIDTH'(1))));

    assign rx_tready = adv[0];
    assign rx_fire   = rx_tvalid & rx_tready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int HI = WIDTH - 1 - gi * CHUNK;
        localparam int LO = WIDTH - (gi + 1) * CHUNK;

        if (gi == 0) begin : g_head
            assign vld_in[gi]  = rx_tvalid;
            assign gray_in[gi] = rx_tdata;
            assign bin_in[gi]  = '0;
            assign err_in[gi]  = step_err;
        end else begin : g_body
            assign vld_in[gi]  = vld_reg[gi-1];
            assign gray_in[gi] = gray_reg[gi-1];
            assign bin_in[gi]  = bin_reg[gi-1];
            assign err_in[gi]  = err_reg[gi-1];
        end

        // A stage may load when downstream is ready or any stage from here to
        // the output still has a hole (that hole absorbs the shift).
        assign adv[gi] = tx_tready | ~(&vld_reg[STAGES-1:gi]);

        assign bin_next[gi] = resolve_chunk(gray_in[gi], bin_in[gi], HI, LO);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_reg   <= '0;
            err_reg   <= '0;
            prev_reg  <= '0;
            first_reg <= 1'b1;
            for (int s = 0; s < STAGES; s++) begin
                gray_reg[s] <= '0;
                bin_reg[s]  <= '0;
            end
        end else begin
            if (rx_fire) begin
                prev_reg  <= rx_tdata;
                first_reg <= 1'b0;
            end
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    vld_reg[s] <= vld_in[s];
                    // Payload only moves with a real word so a drained
                    // stage keeps its last contents.
                    if (vld_in[s]) begin
                        gray_reg[s] <= gray_in[s];
                        bin_reg[s]  <= bin_next[s];
                        err_reg[s]  <= err_in[s];
                    end
                end
            end
        end
    end

    assign tx_tvalid = vld_reg[STAGES-1];
    assign tx_tdata  = bin_reg[STAGES-1];
    assign tx_tuser  = err_reg[STAGES-1];

endmodule

// File: doc/logic_basic_gray2binary_stream.md
LOGIC_BASIC_GRAY2BINARY_STREAM -- requirements
Module: logic_basic_gray2binary_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of the gray input and binary output words; legal range >= 1.
REQ-002 SHALL have parameter STAGES, default 1: number of register stages between input acceptance and output; legal range 1..WIDTH.
REQ-003 SHALL have port aclk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  input  1: reset, asynchronous assertion and deassertion, active-high.
REQ-005 SHALL have port rx_tvalid  input  1: input word valid.
REQ-006 SHALL have port rx_tready  output  1: block can accept an input word.
REQ-007 SHALL have port rx_tdata  input  WIDTH: gray-coded input word.
REQ-008 SHALL have port tx_tvalid  output  1: output word valid.
REQ-009 SHALL have port tx_tready  input  1: downstream can accept an output word.
REQ-010 SHALL have port tx_tdata  output  WIDTH: binary-decoded output word.
REQ-011 SHALL have port tx_tuser  output  1: gray-step error flag travelling with tx_tdata.

Function
REQ-012 SHALL transfer an input word on a cycle where rx_tvalid and rx_tready are both 1; the same rule applies to output with tx_tvalid/tx_tready.
REQ-013 SHALL decode as b[WIDTH-1] = g[WIDTH-1] and b[k] = b[k+1] XOR g[k] for k = WIDTH-2 down to 0; tx_tdata SHALL be bit-identical for every legal STAGES value.
REQ-014 SHALL split the MSB-to-LSB XOR chain across STAGES register stages, each stage resolving at most ceil(WIDTH/STAGES) bits and carrying the remaining gray bits and partial result forward.
REQ-015 SHALL have a latency of exactly STAGES cycles from an input transfer to tx_tvalid rising for that word when tx_tready is held 1.
REQ-016 SHALL sustain one transfer per cycle when tx_tready is held 1 (no bubbles inserted).
REQ-017 SHALL advance stage s only when stage s is empty or stage s+1 advances (per-stage valid bit; last stage's successor is tx_tready); rx_tready SHALL equal the advance condition of stage 0.
REQ-018 SHALL hold tx_tdata, tx_tuser and tx_tvalid stable while tx_tvalid=1 and tx_tready=0.
REQ-019 SHALL preserve word order; no word SHALL be dropped or duplicated under any tx_tready pattern.
REQ-020 SHALL keep a register of the last accepted gray word plus a "first word" flag, both updated only on an input transfer.
REQ-021 SHALL set the word's tx_tuser to 1 when its gray value differs from the previous accepted gray word in 2 or more bit positions; 0 or 1 differing bits SHALL give tx_tuser = 0.
REQ-022 SHALL force tx_tuser = 0 for the first word accepted after reset.
REQ-023 SHALL compute tx_tuser at input acceptance and pipeline it alongside the data through all STAGES.
REQ-024 SHALL, for WIDTH = 1, pass data unchanged (b = g), with latency still STAGES.

Reset
REQ-025 SHALL, while areset = 1, clear all stage valid bits, forcing tx_tvalid = 0 and rx_tready = 1 asynchronously.
REQ-026 SHALL reset tx_tdata = 0, tx_tuser = 0, previous-word register = 0, and set the first-word flag.
REQ-027 SHALL discard all in-flight words when reset is asserted mid-operation; no partially decoded word SHALL appear after release.
REQ-028 SHALL accept a transfer on the first rising edge of aclk after areset deasserts.

Verification
REQ-029 WIDTH=4, STAGES=2, tx_tready=1: send gray 4'b0110 -> after 2 cycles tx_tdata=4'b0100, tx_tuser=0.
REQ-030 WIDTH=4, STAGES=2: stream gray 0,1,3,2,6,7,5,4,12 back-to-back -> tx_tdata 0..8 on consecutive cycles, tx_tuser=0 throughout.
REQ-031 WIDTH=4: send 4'b0110 then 4'b0101 -> second output tx_tdata=4'b0110, tx_tuser=1; first word tx_tuser=0 regardless of value (e.g. 4'b1000 -> 4'b1111).
REQ-032 WIDTH=8, STAGES=3: random tx_tready at 50% with continuous random input -> output sequence equals reference decode in order, outputs stable while stalled, rx_tready=0 only when pipeline full and stalled.
REQ-033 Assert areset with 3 words in flight (STAGES=3) -> tx_tvalid=0 immediately; after release, next input 4'b1000 decodes to 4'b1111 with tx_tuser=0.
REQ-034 Sweep STAGES=1..WIDTH for WIDTH=5 with exhaustive 32-value input -> identical tx_tdata sequences; latency equals STAGES each run.
